nonrestoring_div: RTL and testbench

Sequential signed divider; the inverse of the team's 8x8 Booth multiplier. It takes a 16-bit signed dividend, e.g. a product from the multiplier, and an 8-bit signed divisor. It returns an 8-bit signed quotient and remainder, using one radix-2 restoring iteration per clock on operand magnitudes followed by sign correction. It sits beside the multiplier in the arithmetic datapath and provides a start/busy/done handshake for a controlling FSM.

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 27 ++
 rtl/nonrestoring_div.sv | 88 ++++++++
 tb/tb_nonrestoring_div.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM states and saturation constants for the signed divider
package div_pkg;
  localparam int DW_N = 16;
  localparam int DW_D = 8;
  localparam int ITER = 16;
  localparam logic [DW_D-1:0] Q_MAX = 8'h7F;
  localparam logic [DW_D-1:0] Q_MIN = 8'h80;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring iteration on unsigned magnitudes
// prem: 9-bit partial remainder, din: next dividend bit, dvs: divisor magnitude
// prem_next: kept difference or restored shifted value, qbit: quotient bit
module div_step
  import div_pkg::*;
(
  input  logic [DW_D:0]   prem,
  input  logic            din,
  input  logic [DW_D-1:0] dvs,
  output logic [DW_D:0]   prem_next,
  output logic            qbit
);
  // One guard bit above the 9-bit shifted value so the difference sign is exact
  logic [DW_D+1:0] sh, sub, diff;
  logic [DW_D+1:0] c;
  assign sh = {prem, din};
  assign sub = ~{2'b00, dvs};
  assign c[0] = 1'b1;
  for (genvar i = 0; i <= DW_D + 1; i++) begin : g_fa
    assign diff[i] = sh[i] ^ sub[i] ^ c[i];
    if (i <= DW_D) begin : g_c
      assign c[i+1] = (sh[i] & sub[i]) | (c[i] & (sh[i] ^ sub[i]));
    end
  end
  assign qbit = ~diff[DW_D+1];
  assign prem_next = qbit ? diff[DW_D:0] : sh[DW_D:0];
endmodule

// File: rtl/nonrestoring_div.sv
// nonrestoring_div: sequential 16/8 signed divider, truncating toward zero
// start/dividend/divisor: request and operands, sampled in IDLE
// busy/done: in-flight flag and one-cycle completion pulse
// quotient/remainder/overflow/div_by_zero: results, held until the next completion
module nonrestoring_div
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DW_D-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            overflow,
  output logic            div_by_zero
);
  localparam int CW = $clog2(ITER);
  state_t state, state_d;
  logic [DW_N-1:0] mag;
  logic [DW_D-1:0] dvs, rem_lo, q_d, r_d;
  logic [DW_D:0] prem, prem_d;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, dz, qbit, ovf;
  div_step u_step (
    .prem     (prem),
    .din      (mag[DW_N-1]),
    .dvs      (dvs),
    .prem_next(prem_d),
    .qbit     (qbit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state == IDLE ? (start ? (divisor == '0 ? FIX : RUN) : IDLE) :
              state == RUN  ? (cnt == CW'(ITER - 1) ? FIX : RUN) : IDLE;
  end
  // mag holds the dividend magnitude and fills with quotient bits as it shifts out
  always_comb begin
    ovf = sign_q ? (mag > DW_N'(128)) : (mag > DW_N'(127));
    q_d = dz ? '0 : ovf ? (sign_q ? Q_MIN : Q_MAX) :
          sign_q ? -mag[DW_D-1:0] : mag[DW_D-1:0];
    r_d = dz ? rem_lo : ovf ? '0 : sign_r ? -prem[DW_D-1:0] : prem[DW_D-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
      mag <= '0;
      dvs <= '0;
      rem_lo <= '0;
      prem <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start) begin
        mag <= dividend[DW_N-1] ? -dividend : dividend;
        dvs <= divisor[DW_D-1] ? -divisor : divisor;
        sign_q <= dividend[DW_N-1] ^ divisor[DW_D-1];
        sign_r <= dividend[DW_N-1];
        dz <= divisor == '0;
        rem_lo <= dividend[DW_D-1:0];
        prem <= '0;
        cnt <= '0;
      end
      if (state == RUN) begin
        mag <= {mag[DW_N-2:0], qbit};
        prem <= prem_d;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        quotient <= q_d;
        remainder <= r_d;
        overflow <= ovf & ~dz;
        div_by_zero <= dz;
      end
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_nonrestoring_div.sv
// tb_nonrestoring_div: directed checks of the signed divider results and handshake timing
module tb_nonrestoring_div;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic busy, done, overflow, div_by_zero;
  logic [7:0] quotient, remainder;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  nonrestoring_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_q"}, 32'(quotient), 0);
    check({tag, "_r"}, 32'(remainder), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_dz"}, 32'(div_by_zero), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask
  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic eo,
                       input logic ez, input int lat);
    int k;
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    check({tag, "_busy"}, 32'(busy), 1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(ez));
    check({tag, "_busy_end"}, 32'(busy), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask
  initial begin
    int nd, d1, d2;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("p100_7", 16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 17);
    do_op("m100_7", -16'sd100, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 17);
    do_op("q_min", 16'd16256, 8'h81, 8'h80, 8'h00, 1'b0, 1'b0, 17);
    do_op("neg_ovf", 16'hC000, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 17);
    do_op("pos_ovf", 16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b1, 1'b0, 17);
    do_op("dz", 16'd1234, 8'h00, 8'h00, 8'hD2, 1'b0, 1'b1, 1);
    // start pulsed mid-operation must be ignored
    @(negedge clk);
    dividend = 16'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    d1 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        start = 1'b1;
        dividend = 16'd9;
        divisor = 8'd3;
      end
      if (k == 5) start = 1'b0;
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k;
      end
    end
    check("ign_lat", d1, 17);
    check("ign_ndone", nd, 1);
    check("ign_q", 32'(quotient), 32'h0E);
    // start held through the done cycle issues a second operation
    @(negedge clk);
    dividend = 16'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    dividend = -16'sd100;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (k == 18) start = 1'b0;
      if (done) begin
        nd++;
        if (d1 < 0) begin
          d1 = k;
          check("b2b_q1", 32'(quotient), 32'h0E);
          check("b2b_r1", 32'(remainder), 32'h02);
        end else begin
          d2 = k;
          check("b2b_q2", 32'(quotient), 32'hF2);
          check("b2b_r2", 32'(remainder), 32'hFE);
        end
      end
    end
    check("b2b_d1", d1, 17);
    check("b2b_d2", d2, 35);
    check("b2b_ndone", nd, 2);
    // asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 16'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("mid_rst_ndone", nd, 0);
    do_op("p1000_m8", 16'd1000, 8'hF8, 8'h83, 8'h00, 1'b0, 1'b0, 17);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
